// File: rtl/fpadd_pkg.sv
// Shared types and helpers for the FP adder scheduler: IEEE-754 single
// precision field view, result classification flags and scheduler states.
package fpadd_pkg;

  localparam logic [7:0] EXP_MAX = 8'hFF;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float32_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fpflags_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Classify a single-precision word. Subnormals deliberately set no flag.
  function automatic fpflags_t classify(input float32_t f);
    fpflags_t r;
    r.nan  = (f.exp == EXP_MAX) && (f.mant != '0);
    r.inf  = (f.exp == EXP_MAX) && (f.mant == '0);
    r.zero = (f.exp == 8'd0)    && (f.mant == '0);
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// found when searching upward from last+1, wrapping modulo N. The pointer
// itself is owned by the instantiating block.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic                 grant_valid,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] w_idx;

  // Walk the N candidate slots starting just after the previous winner.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    w_idx       = '0;
    for (int k = 1; k <= N; k++) begin
      w_idx = IW'((int'(last) + k) % N);
      if (!grant_valid && req[w_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = w_idx;
      end
    end
  end

endmodule

// File: rtl/fpadd_scheduler.sv
// Time-shares one combinational FP adder datapath among NREQ requesters.
// A round-robin winner's operands are registered onto the adder, held for
// EXEC_CYCLES cycles, and the sum is returned on a tagged response port
// with back-pressure. Exactly one operation is in flight at a time.
module fpadd_scheduler
  import fpadd_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*32-1:0]      req_a,
  input  logic [NREQ*32-1:0]      req_b,
  output logic [31:0]             fa_a,
  output logic [31:0]             fa_b,
  input  logic [31:0]             fa_result,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [31:0]             rsp_result,
  output logic [2:0]              rsp_flags
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = 4;

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_EXEC = 2'(EXEC);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  logic [1:0]      r_state;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_fa_a;
  logic [31:0]     r_fa_b;
  logic [IW-1:0]   r_id;
  logic [31:0]     r_result;
  fpflags_t        r_flags;

  logic            w_gvalid;
  logic [IW-1:0]   w_gidx;
  logic [NREQ-1:0] w_ready;
  logic            w_accept;
  logic [31:0]     w_op_a;
  logic [31:0]     w_op_b;

  rr_arbiter #(
    .N (NREQ)
  ) u_arb (
    .req         (req_valid),
    .last        (r_last),
    .grant_valid (w_gvalid),
    .grant_idx   (w_gidx)
  );

  // Ready goes only to the arbitration winner, only in IDLE and out of reset.
  always_comb begin
    w_ready = '0;
    if (rst_n && (r_state == ST_IDLE) && w_gvalid) begin
      w_ready[w_gidx] = 1'b1;
    end
  end

  assign req_ready = w_ready;
  assign w_accept  = |(req_valid & w_ready);

  // Operand mux selecting the winner's A/B words.
  always_comb begin
    w_op_a = '0;
    w_op_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gidx == IW'(i)) begin
        w_op_a = req_a[i*32 +: 32];
        w_op_b = req_b[i*32 +: 32];
      end
    end
  end

  // Scheduler FSM: accept, hold operands for the execution window, then
  // present the captured result until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_last   <= IW'(NREQ - 1);
      r_cnt    <= '0;
      r_fa_a   <= '0;
      r_fa_b   <= '0;
      r_id     <= '0;
      r_result <= '0;
      r_flags  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_fa_a  <= w_op_a;
            r_fa_b  <= w_op_b;
            r_id    <= w_gidx;
            r_last  <= w_gidx;
            r_cnt   <= CW'(EXEC_CYCLES - 1);
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (r_cnt == '0) begin
            r_result <= fa_result;
            r_flags  <= classify(float32_t'(fa_result));
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign fa_a       = r_fa_a;
  assign fa_b       = r_fa_b;
  assign rsp_valid  = (r_state == ST_DONE);
  assign rsp_id     = r_id;
  assign rsp_result = r_result;
  assign rsp_flags  = r_flags;

endmodule

// File: tb/tb_fpadd_scheduler.sv
// Bench for fpadd_scheduler: a behavioural single-precision adder stands in
// for the shared datapath; directed steps drive requests, push expected
// responses onto a scoreboard and pop them as responses appear.
module tb_fpadd_scheduler;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 1: NREQ=4, EXEC_CYCLES=2
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  fa_a, fa_b, fa_result;
  logic         rsp_valid, rsp_ready;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result;
  logic [2:0]   rsp_flags;

  // Instance 2: NREQ=4, EXEC_CYCLES=4
  logic         rst2_n;
  logic [3:0]   req_valid2;
  logic [3:0]   req_ready2;
  logic [127:0] req_a2, req_b2;
  logic [31:0]  fa_a2, fa_b2, fa_result2;
  logic         rsp_valid2, rsp_ready2;
  logic [1:0]   rsp_id2;
  logic [31:0]  rsp_result2;
  logic [2:0]   rsp_flags2;

  function automatic real to_real(input logic [31:0] f);
    real m;
    int  e;
    if (f[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    m = m * (2.0 ** e);
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    int          e;
    real         rs;
    if (a[30:23] == 8'hFF && a[22:0] != 23'd0) return a;
    if (b[30:23] == 8'hFF && b[22:0] != 23'd0) return b;
    if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FFFFFFF;
    if (a[30:23] == 8'hFF) return a;
    if (b[30:23] == 8'hFF) return b;
    rs = to_real(a) + to_real(b);
    d  = $realtobits(rs);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 1023 + 127;
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    if (e <= 0) return {d[63], 31'd0};
    return {d[63], e[7:0], d[51:29]};
  endfunction

  assign fa_result  = fp_add(fa_a, fa_b);
  assign fa_result2 = fp_add(fa_a2, fa_b2);

  fpadd_scheduler #(.NREQ(4), .EXEC_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .fa_a(fa_a), .fa_b(fa_b), .fa_result(fa_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );

  fpadd_scheduler #(.NREQ(4), .EXEC_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst2_n), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_a(req_a2), .req_b(req_b2), .fa_a(fa_a2), .fa_b(fa_b2), .fa_result(fa_result2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_id(rsp_id2),
    .rsp_result(rsp_result2), .rsp_flags(rsp_flags2)
  );

  typedef struct {
    logic [1:0]  id;
    logic [31:0] res;
    logic [2:0]  fl;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Acceptance monitor for instance 1: cycle count after the accepting edge and winner index.
  int   cyc = 0;
  int   acc_cyc[$];
  int   acc_id[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && ((req_valid & req_ready) != 4'd0)) begin
      int w;
      w = 0;
      for (int i = 0; i < 4; i++) if (req_valid[i] & req_ready[i]) w = i;
      acc_cyc.push_back(cyc + 1);
      acc_id.push_back(w);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [31:0] res, input logic [2:0] fl);
    exp_t e;
    e.id = id; e.res = res; e.fl = fl;
    sb.push_back(e);
  endtask

  // Called at a negedge; waits (bounded) for instance-1 response and scores it.
  task automatic wait_rsp(input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check({tag, "_unexpected_rsp"}, 32'(rsp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check({tag, "_id"},     32'(rsp_id),    32'(e.id));
        check({tag, "_result"}, rsp_result,     e.res);
        check({tag, "_flags"},  32'(rsp_flags), 32'(e.fl));
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int   n, base;
    exp_t e;
    rst_n = 1'b0; rst2_n = 1'b0;
    req_valid = 4'hF; req_valid2 = 4'd0;
    req_a = '0; req_b = '0; req_a2 = '0; req_b2 = '0;
    rsp_ready = 1'b1; rsp_ready2 = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ready_forced0", 32'(req_ready), 32'd0);
    rst_n = 1'b1; rst2_n = 1'b1; req_valid = 4'd0;
    #1;
    check("rst_fa_a", fa_a, 32'd0);
    check("rst_fa_b", fa_b, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_flags", 32'(rsp_flags), 32'd0);

    // Single op: requester 2, 1.0 + 2.0
    @(negedge clk);
    req_a[2*32 +: 32] = 32'h3F800000;
    req_b[2*32 +: 32] = 32'h40000000;
    req_valid = 4'b0100;
    #1;
    check("single_ready", 32'(req_ready), 32'b0100);
    push(2'd2, 32'h40400000, 3'b000);
    @(negedge clk);
    req_valid = 4'd0;
    check("single_fa_a", fa_a, 32'h3F800000);
    check("single_fa_b", fa_b, 32'h40000000);
    check("single_exec_ready", 32'(req_ready), 32'd0);
    wait_rsp("single");
    check("single_latency", 32'(cyc - acc_cyc[acc_cyc.size()-1]), 32'd2);
    @(negedge clk);

    // Fairness: requesters 0,1,3 held valid after reset
    do_reset();
    base = acc_id.size();
    req_a[0*32 +: 32] = 32'h3F800000; req_b[0*32 +: 32] = 32'h3F800000;
    req_a[1*32 +: 32] = 32'h3F800000; req_b[1*32 +: 32] = 32'h40000000;
    req_a[3*32 +: 32] = 32'h40000000; req_b[3*32 +: 32] = 32'h40000000;
    req_valid = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      push(2'd0, 32'h40000000, 3'b000);
      push(2'd1, 32'h40400000, 3'b000);
      push(2'd3, 32'h40800000, 3'b000);
    end
    for (int i = 0; i < 6; i++) begin
      wait_rsp("fair");
      if (i == 5) req_valid = 4'd0;
      @(negedge clk);
    end
    check("fair_accept_count", 32'(acc_id.size() - base), 32'd6);
    if (acc_id.size() >= base + 6) begin
      for (int i = 0; i < 6; i++) begin
        check("fair_grant_order", 32'(acc_id[base+i]), (i % 3 == 2) ? 32'd3 : 32'(i % 3));
        if (i > 0) check("fair_spacing", 32'(acc_cyc[base+i] - acc_cyc[base+i-1]), 32'd4);
      end
    end

    // Back-pressure: requester 1, 2.0 + 2.0, consumer stalls 10 cycles
    rsp_ready = 1'b0;
    req_a[1*32 +: 32] = 32'h40000000; req_b[1*32 +: 32] = 32'h40000000;
    req_valid = 4'b0010;
    push(2'd1, 32'h40800000, 3'b000);
    @(negedge clk);
    req_valid = 4'd0;
    wait_rsp("bp");
    req_valid = 4'b1001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_id", 32'(rsp_id), 32'd1);
      check("bp_hold_result", rsp_result, 32'h40800000);
      check("bp_hold_flags", 32'(rsp_flags), 32'd0);
      check("bp_no_ready", 32'(req_ready), 32'd0);
    end
    n = acc_id.size();
    rsp_ready = 1'b1;
    #1;
    check("bp_handshake_no_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("bp_released", 32'(rsp_valid), 32'd0);
    check("bp_no_accept_in_done", 32'(acc_id.size()), 32'(n));
    check("bp_next_winner", 32'(req_ready), 32'b1000);
    req_valid = 4'd0;

    // Specials: +inf + -inf, then 1.0 + -1.0
    @(negedge clk);
    req_a[0*32 +: 32] = 32'h7F800000; req_b[0*32 +: 32] = 32'hFF800000;
    req_valid = 4'b0001;
    push(2'd0, 32'h7FFFFFFF, 3'b100);
    @(negedge clk);
    req_valid = 4'd0;
    wait_rsp("inf_minus_inf");
    @(negedge clk);
    req_a[0*32 +: 32] = 32'h3F800000; req_b[0*32 +: 32] = 32'hBF800000;
    req_valid = 4'b0001;
    push(2'd0, 32'h00000000, 3'b001);
    @(negedge clk);
    req_valid = 4'd0;
    wait_rsp("cancel_zero");
    @(negedge clk);

    // Reset mid-EXEC on the EXEC_CYCLES=4 instance
    req_a2[1*32 +: 32] = 32'h40000000; req_b2[1*32 +: 32] = 32'h40000000;
    req_a2[0*32 +: 32] = 32'h3F800000; req_b2[0*32 +: 32] = 32'h40000000;
    req_a2[2*32 +: 32] = 32'h40000000; req_b2[2*32 +: 32] = 32'h3F800000;
    req_valid2 = 4'b0010;
    #1;
    check("mid_ready", 32'(req_ready2), 32'b0010);
    @(negedge clk);
    req_valid2 = 4'd0;
    check("mid_fa_a", fa_a2, 32'h40000000);
    @(negedge clk);
    rst2_n = 1'b0;
    req_valid2 = 4'b0101;
    #1;
    check("mid_rst_ready0", 32'(req_ready2), 32'd0);
    @(negedge clk);
    rst2_n = 1'b1;
    req_valid2 = 4'd0;
    #1;
    check("mid_rst_fa_a", fa_a2, 32'd0);
    check("mid_rst_fa_b", fa_b2, 32'd0);
    check("mid_rst_rsp_id", 32'(rsp_id2), 32'd0);
    check("mid_rst_rsp_result", rsp_result2, 32'd0);
    check("mid_rst_rsp_flags", 32'(rsp_flags2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      check("mid_no_rsp", 32'(rsp_valid2), 32'd0);
      @(negedge clk);
    end
    req_valid2 = 4'b0101;
    #1;
    check("mid_next_winner", 32'(req_ready2), 32'b0001);
    push(2'd0, 32'h40400000, 3'b000);
    @(negedge clk);
    req_valid2 = 4'd0;
    n = 0;
    while (!rsp_valid2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_after_rsp_valid", 32'(rsp_valid2), 32'd1);
    if (rsp_valid2 && sb.size() > 0) begin
      e = sb.pop_front();
      check("mid_after_id", 32'(rsp_id2), 32'(e.id));
      check("mid_after_result", rsp_result2, e.res);
      check("mid_after_flags", 32'(rsp_flags2), 32'(e.fl));
    end
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
